// File: rtl/htg_spi_pkg.sv
// Shared types and constants for the HTG FMC 3-wire SPI arbiter.
package htg_spi_pkg;

    localparam int CMD_BITS   = 26;
    localparam int FRAME_BITS = 24;
    localparam int RD_BITS    = 8;
    localparam int DEV_LSB    = 24;
    localparam int DEV_BITS   = 2;
    localparam int RW_BIT     = 23;
    localparam int ADDR_LSB   = 8;
    localparam int ADDR_BITS  = 15;
    localparam int WDATA_BITS = 8;

    typedef enum logic [1:0] {
        DEV_HMC7044 = 2'd0,
        DEV_ADF4371 = 2'd1,
        DEV_AD9213  = 2'd2,
        DEV_INVALID = 2'd3
    } dev_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_ERR
    } state_t;

    // Pin order {slen_hmc7044, cs_adf4371, csb_ad9213}
    localparam logic [2:0] SEL_NONE = 3'b011;

    function automatic logic [2:0] sel_pins(input dev_t dev);
        unique case (dev)
            DEV_HMC7044: sel_pins = 3'b111;
            DEV_ADF4371: sel_pins = 3'b001;
            DEV_AD9213:  sel_pins = 3'b010;
            DEV_INVALID: sel_pins = SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/htg_spi_shifter.sv
// SPI bit engine: SCLK divider, 24-bit MSB-first shift, read sampling
// and the data-pin turnaround for the last 8 bits of a read frame.
module htg_spi_shifter
    import htg_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  data_i,
    output logic                  sclk,
    output logic                  data_o,
    output logic                  data_oe,
    output logic                  done,
    output logic [RD_BITS-1:0]    rdata
);

    localparam int DW = $clog2(2 * CLK_DIV);
    localparam logic [DW-1:0] BIT_END = DW'(2 * CLK_DIV - 1);
    localparam logic [DW-1:0] RISE = DW'(CLK_DIV - 1);

    logic                  active;
    logic                  rd;
    logic                  bit_end;
    logic [DW-1:0]         cnt;
    logic [4:0]            bit_idx;
    logic [FRAME_BITS-1:0] sr;

    assign bit_end = active && (cnt == BIT_END);
    assign done    = bit_end && (bit_idx == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            rd      <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            sr      <= '0;
            sclk    <= 1'b0;
            data_o  <= 1'b0;
            data_oe <= 1'b0;
            rdata   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            rd      <= frame[FRAME_BITS-1];
            cnt     <= '0;
            bit_idx <= 5'(FRAME_BITS - 1);
            sr      <= {frame[FRAME_BITS-2:0], 1'b0};
            sclk    <= 1'b0;
            data_o  <= frame[FRAME_BITS-1];
            data_oe <= 1'b1;
            rdata   <= '0;
        end else if (active) begin
            // Sample at the end of the high phase of read bits 7..0
            if (rd && bit_end && bit_idx < 5'(RD_BITS))
                rdata <= {rdata[RD_BITS-2:0], data_i};
            if (!bit_end) begin
                cnt  <= cnt + 1'b1;
                sclk <= (cnt >= RISE);
            end else if (done) begin
                active  <= 1'b0;
                sclk    <= 1'b0;
                data_o  <= 1'b0;
                data_oe <= 1'b0;
            end else begin
                cnt     <= '0;
                sclk    <= 1'b0;
                bit_idx <= bit_idx - 1'b1;
                data_o  <= sr[FRAME_BITS-1];
                sr      <= {sr[FRAME_BITS-2:0], 1'b0};
                if (rd && bit_idx == 5'(RD_BITS))
                    data_oe <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/htg_fmc_spi_arbiter.sv
// Two-requester arbiter and 3-wire SPI master for one HTG FMC.
// Define HTG_SPI_RR_EN for round-robin; otherwise R0 has fixed priority.
module htg_fmc_spi_arbiter
    import htg_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          req,
    input  logic [CMD_BITS-1:0] cmd0,
    input  logic [CMD_BITS-1:0] cmd1,
    output logic [1:0]          ack,
    output logic [RD_BITS-1:0]  rdata,
    output logic                err,
    output logic                busy,
    output logic                spi_slen_hmc7044,
    output logic                spi_cs_adf4371,
    output logic                spi_csb_ad9213,
    output logic                spi_clk,
    output logic                spi_data_o,
    output logic                spi_data_oe,
    input  logic                spi_data_i
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLK_DIV - 1);

    state_t              state;
    state_t              nxt;
    logic [CNT_W-1:0]    cnt;
    logic                win;
    logic                gnt;
    logic                gnt_d;
    logic [CMD_BITS-1:0] cmd_w;
    dev_t                dev_w;
    logic                start;
    logic                fire;
    logic                sh_done;
    logic [RD_BITS-1:0]  sh_rdata;
    logic [RD_BITS-1:0]  rdata_d;
    logic [2:0]          sel_q;
    logic [2:0]          sel_d;
    logic [1:0]          ack_d;
    logic                err_d;
    logic                busy_d;

`ifdef HTG_SPI_RR_EN
    logic last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= 1'b1;
        else if (state == ST_IDLE && |req)
            last <= win;
    end

    assign win = req[1] & (~req[0] | ~last);
`else
    assign win = req[1] & ~req[0];
`endif

    assign cmd_w = win ? cmd1 : cmd0;
    assign dev_w = dev_t'(cmd_w[DEV_LSB +: DEV_BITS]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE:  if (|req)
                          nxt = (dev_w == DEV_INVALID) ? ST_ERR : ST_SHIFT;
            ST_SHIFT: if (sh_done) nxt = ST_HOLD;
            ST_HOLD:  if (cnt == CNT_END) nxt = ST_GAP;
            ST_GAP:   if (cnt == CNT_END) nxt = ST_IDLE;
            ST_ERR:   nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start   = (state == ST_IDLE) && (nxt == ST_SHIFT);
        fire    = ((state == ST_HOLD) && (nxt == ST_GAP)) || (nxt == ST_ERR);
        gnt_d   = (state == ST_IDLE) ? win : gnt;
        ack_d   = fire ? {gnt_d, ~gnt_d} : 2'b00;
        err_d   = (nxt == ST_ERR);
        rdata_d = (state == ST_HOLD && nxt == ST_GAP) ? sh_rdata : '0;
        busy_d  = (nxt != ST_IDLE);
        sel_d   = sel_q;
        if (start)
            sel_d = sel_pins(dev_w);
        else if (nxt == ST_GAP)
            sel_d = SEL_NONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt   <= 1'b0;
            sel_q <= SEL_NONE;
            ack   <= 2'b00;
            err   <= 1'b0;
            rdata <= '0;
            busy  <= 1'b0;
        end else begin
            gnt   <= gnt_d;
            sel_q <= sel_d;
            ack   <= ack_d;
            err   <= err_d;
            rdata <= rdata_d;
            busy  <= busy_d;
        end
    end

    assign {spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213} = sel_q;

    htg_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .frame   (cmd_w[FRAME_BITS-1:0]),
        .data_i  (spi_data_i),
        .sclk    (spi_clk),
        .data_o  (spi_data_o),
        .data_oe (spi_data_oe),
        .done    (sh_done),
        .rdata   (sh_rdata)
    );

endmodule

// File: tb/tb_htg_fmc_spi_arbiter.sv
// Scoreboard bench for htg_fmc_spi_arbiter with a 3-wire slave model.
// Expected order under contention follows HTG_SPI_RR_EN.
module tb_htg_fmc_spi_arbiter;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [25:0] cmd0;
    logic [25:0] cmd1;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic        spi_slen_hmc7044;
    logic        spi_cs_adf4371;
    logic        spi_csb_ad9213;
    logic        spi_clk;
    logic        spi_data_o;
    logic        spi_data_oe;
    logic        spi_data_i;

    htg_fmc_spi_arbiter #(
        .CLK_DIV (D)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .cmd0             (cmd0),
        .cmd1             (cmd1),
        .ack              (ack),
        .rdata            (rdata),
        .err              (err),
        .busy             (busy),
        .spi_slen_hmc7044 (spi_slen_hmc7044),
        .spi_cs_adf4371   (spi_cs_adf4371),
        .spi_csb_ad9213   (spi_csb_ad9213),
        .spi_clk          (spi_clk),
        .spi_data_o       (spi_data_o),
        .spi_data_oe      (spi_data_oe),
        .spi_data_i       (spi_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ack;
        logic [7:0]  rdata;
        logic        err;
        int          cyc;
        logic [23:0] frame;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          nb = 0;
    logic [23:0] mosi = '0;
    logic        prev_sclk = 1'b0;
    logic [7:0]  slv_byte = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] r,
                        input logic e, input int c, input logic [23:0] f);
        exp_t x;
        x.ack = a;
        x.rdata = r;
        x.err = e;
        x.cyc = c;
        x.frame = f;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_ack(output logic [1:0] a);
        a = 2'b00;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                return;
            end
        end
        chk("ack_timeout", 32'(ack != 2'b00), 1);
    endtask

    function automatic int win_at(input int k);
`ifdef HTG_SPI_RR_EN
        return k % 2;
`else
        return (k < 4) ? 0 : 1;
`endif
    endfunction

    // Slave model and scoreboard: capture MOSI on SCLK rises, answer reads
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            nb = 0;
            mosi = '0;
        end else begin
            if (spi_clk && !prev_sclk) begin
                mosi = {mosi[22:0], spi_data_o};
                nb++;
            end
            if (ack != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(ack), 0);
                end else begin
                    e = sb.pop_front();
                    chk("ack", 32'(ack), 32'(e.ack));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("err", 32'(err), 32'(e.err));
                    chk("ack_cyc", cyc, e.cyc);
                    if (e.err) begin
                        chk("err_nbits", nb, 0);
                    end else begin
                        chk("nbits", nb, 24);
                        chk("frame", 32'(mosi), 32'(e.frame));
                    end
                end
                nb = 0;
            end
        end
        spi_data_i = (nb >= 17 && nb <= 24) ? slv_byte[3'(24 - nb)] : 1'b0;
        prev_sclk = spi_clk;
    end

    initial begin
        int c;
        int c2;
        int q0;
        int q1;
        int nfr;
        int w;
        logic [1:0] a;
        logic [23:0] f0;
        logic [23:0] f1;

        reset_n = 1'b0;
        req = 2'b00;
        cmd0 = '0;
        cmd1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out",
            {spi_clk, spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213,
             spi_data_o, spi_data_oe, ack, rdata, err, busy},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0});
        reset_n = 1'b1;
        @(negedge clk);

        // Write to AD9213 from R0
        c = cyc;
        cmd0 = {2'd2, 1'b0, 15'h0008, 8'hA5};
        req[0] = 1'b1;
        push(2'b01, 8'h00, 1'b0, c + 1 + 49 * D, 24'h0008A5);
        wait_cyc(c + 1);
        chk("wr_sel_on", {spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213}, 3'b010);
        chk("wr_oe", 32'(spi_data_oe), 1);
        chk("wr_bit23", 32'(spi_data_o), 0);
        chk("wr_busy", 32'(busy), 1);
        wait_cyc(c + 49 * D);
        chk("wr_csb_last", 32'(spi_csb_ad9213), 0);
        wait_cyc(c + 1 + 49 * D);
        chk("wr_csb_off", 32'(spi_csb_ad9213), 1);
        req[0] = 1'b0;
        wait_cyc(c + 50 * D);
        chk("wr_busy_gap", 32'(busy), 1);
        wait_cyc(c + 1 + 50 * D);
        chk("wr_busy_idle", 32'(busy), 0);

        // Invalid device
        wait_cyc(cyc + 3);
        c = cyc;
        cmd0 = {2'd3, 1'b0, 15'h0000, 8'h00};
        req[0] = 1'b1;
        push(2'b01, 8'h00, 1'b1, c + 1, 24'h0);
        wait_cyc(c + 1);
        chk("inv_sel", {spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213}, 3'b011);
        chk("inv_sclk_oe", {spi_clk, spi_data_oe}, 2'b00);
        chk("inv_busy", 32'(busy), 1);
        req[0] = 1'b0;
        wait_cyc(c + 2);
        chk("inv_busy_idle", 32'(busy), 0);

        // Read from HMC7044 via R1
        wait_cyc(cyc + 3);
        c = cyc;
        slv_byte = 8'h5C;
        cmd1 = {2'd0, 1'b1, 15'h0001, 8'h00};
        req[1] = 1'b1;
        push(2'b10, 8'h5C, 1'b0, c + 1 + 49 * D, 24'h800100);
        wait_cyc(c + 1);
        chk("rd_sel_on", {spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213}, 3'b111);
        chk("rd_bit23", 32'(spi_data_o), 1);
        wait_cyc(c + 16 * 2 * D);
        chk("rd_oe_bit8", 32'(spi_data_oe), 1);
        wait_cyc(c + 1 + 16 * 2 * D);
        chk("rd_oe_bit7", 32'(spi_data_oe), 0);
        wait_cyc(c + 48 * D);
        chk("rd_oe_bit0", 32'(spi_data_oe), 0);
        wait_cyc(c + 1 + 49 * D);
        req[1] = 1'b0;
        wait_cyc(c + 1 + 50 * D);

        // Contention, both requesters held across several frames
        wait_cyc(cyc + 3);
        c = cyc;
        f0 = 24'h001011;
        f1 = 24'h002022;
        cmd0 = {2'd1, 1'b0, 15'h0010, 8'h11};
        cmd1 = {2'd0, 1'b0, 15'h0020, 8'h22};
`ifdef HTG_SPI_RR_EN
        nfr = 4;
        q0 = 2;
        q1 = 2;
`else
        nfr = 5;
        q0 = 4;
        q1 = 1;
`endif
        slv_byte = 8'h00;
        req = 2'b11;
        for (int k = 0; k < nfr; k++) begin
            w = win_at(k);
            push((w == 1) ? 2'b10 : 2'b01, 8'h00, 1'b0,
                 c + 1 + 49 * D + k * (50 * D + 1), (w == 1) ? f1 : f0);
        end
        for (int k = 0; k < nfr; k++) begin
            wait_ack(a);
            if (a[0]) begin
                q0--;
                if (q0 == 0) req[0] = 1'b0;
            end
            if (a[1]) begin
                q1--;
                if (q1 == 0) req[1] = 1'b0;
            end
        end
        req = 2'b00;
        wait_cyc(cyc + 2 * D + 3);

        // Reset during bit 10, request held through release
        c = cyc;
        slv_byte = 8'h5C;
        cmd0 = {2'd1, 1'b1, 15'h4321, 8'h00};
        req[0] = 1'b1;
        wait_cyc(c + 1 + 13 * 2 * D + D);
        chk("rst_pre_sclk", 32'(spi_clk), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_out",
            {spi_clk, spi_slen_hmc7044, spi_cs_adf4371, spi_csb_ad9213,
             spi_data_o, spi_data_oe, ack, rdata, err, busy},
            {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        c2 = cyc;
        push(2'b01, 8'h5C, 1'b0, c2 + 1 + 49 * D, 24'hC32100);
        wait_cyc(c2 + 1);
        chk("rst_restart_cs", 32'(spi_cs_adf4371), 0);
        chk("rst_restart_bit23", 32'(spi_data_o), 1);
        chk("rst_restart_busy", 32'(busy), 1);
        wait_cyc(c2 + 1 + 49 * D);
        req[0] = 1'b0;

        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        repeat (2 * D + 2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/htg_fmc_spi_arbiter.md
# htg_fmc_spi_arbiter

Shares one HTG FMC 3-wire SPI bus between two command requesters: R0 is the software/register path and R1 is the power-up init sequencer. The bus reaches three devices: HMC7044 (SLEN, active-high), ADF4371 (CS, active-low) and AD9213 (CSB, active-low). There is one instance per FMC, placed between the requesters and the top-level IOBUF on `spi_x_data`. The block arbitrates requests, serialises 24-bit frames, handles the read turnaround on the shared data pin and returns readback data.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles. Minimum 2. With a 200 MHz clock this gives 25 MHz SCLK.
- `clk` in, 1: system clock, single domain.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req` in, 2: request level per requester. Bit 0 = R0, bit 1 = R1.
- `cmd0`, `cmd1` in, 26 each: `{dev[25:24], rw[23], addr[22:8], wdata[7:0]}`.
  - dev: 0 = HMC7044, 1 = ADF4371, 2 = AD9213, 3 = invalid.
  - rw: 1 = read.
- `ack` out, 2: one-cycle completion pulse per requester.
- `rdata` out, 8: read byte, valid while `ack` is high. Zero for writes.
- `err` out, 1: valid while `ack` is high. Set for dev = 3.
- `busy` out, 1: high from capture until return to IDLE.
- `spi_slen_hmc7044`, `spi_cs_adf4371`, `spi_csb_ad9213` out, 1 each: device selects.
- `spi_clk` out, 1: SCLK, idles low.
- `spi_data_o` out, 1; `spi_data_oe` out, 1; `spi_data_i` in, 1: 3-wire data, split for the external IOBUF.

## Operation
- **Requester handshake**
  - A requester holds `req` high with a stable `cmd` until its `ack` pulse.
  - If `req` is still high in the cycle after `ack`, that is a new request.
  - Requests that arrive while `busy` is high wait. They are never dropped.
- **Arbitration in IDLE:** fixed priority, R0 beats R1 on simultaneous requests.
- **States:** IDLE → SHIFT → HOLD → GAP → IDLE; ERR handles invalid dev.
  - IDLE: on any `req`, capture the winner's `cmd` and go to SHIFT. If dev = 3, go to ERR instead.
  - ERR: pulse `ack` for the winner with `err` = 1. No select, SCLK or data activity. Then go to IDLE.
  - SHIFT: 24 bits, MSB first; the frame is `{rw, addr, wdata}`. For each bit, SCLK is low for CLK_DIV cycles, then high for CLK_DIV cycles. `spi_data_o` changes only in the first low cycle of a bit.
  - HOLD: SCLK low for CLK_DIV cycles with the select still active.
  - GAP: select deasserted, `ack` pulsed in the first GAP cycle, then CLK_DIV cycles of idle. Then go to IDLE.
- **Device frame format:** the block does not modify `addr`. HMC7044 frames need `addr[14:13]` = 0, which is the multibyte field; the requester is responsible for this.
- **Read turnaround (rw = 1)**
  - `spi_data_oe` drops in the first low cycle of bit 7 and stays low until IDLE.
  - `spi_data_i` is sampled in the last high cycle of each of bits 7..0 and shifted into `rdata`.
- **Select mapping:** exactly one select is active per frame, chosen by dev.
- **Reset mid-operation:** asynchronous return to IDLE. All outputs go to their reset values immediately. No `ack` is issued for the aborted frame. A request still held after reset release restarts from bit 23.

## Timing
- **Reset values:**
  - `spi_clk` = 0, `spi_slen_hmc7044` = 0.
  - `spi_cs_adf4371` = 1, `spi_csb_ad9213` = 1.
  - `spi_data_o` = 0, `spi_data_oe` = 0.
  - `ack` = 0, `rdata` = 0, `err` = 0, `busy` = 0.
- All outputs are registered.
- Capture happens at cycle T. At T+1 the select is active, `spi_data_oe` = 1, `spi_data_o` = bit 23, and `busy` = 1.
- **Select active window:** 49·CLK_DIV cycles (48·CLK_DIV for SHIFT plus CLK_DIV for HOLD).
- **`ack` timing:**
  - Normal frame: `ack` at T+1+49·CLK_DIV, which is 197 cycles for CLK_DIV = 4. `rdata` is valid in that same cycle.
  - Invalid dev: `ack` at T+1.
- **Back-to-back spacing:** the next capture is no earlier than T+1+50·CLK_DIV.
- `busy` falls in the same cycle the state returns to IDLE.

## Configuration
- `HTG_SPI_RR_EN` defined: round-robin arbitration. The last-granted requester gets the lower priority on the next simultaneous contention.
- `HTG_SPI_RR_EN` undefined: fixed priority, R0 always wins. The last-grant register is not built.

## Structure
- **Package `htg_spi_pkg`:**
  - dev encodings (`DEV_HMC7044`, `DEV_ADF4371`, `DEV_AD9213`).
  - cmd field offsets and widths (26-bit command, 24-bit frame).
  - state enum.
  - `FRAME_BITS` = 24, `RD_BITS` = 8.
- **Sub-module `htg_spi_shifter`:** the bit engine, covering the CLK_DIV divider, bit counter, shift/sample registers and OE turnaround. It is started by a strobe from the arbiter FSM and returns a done strobe. Arbitration, select decode and the ack/err logic stay in `htg_fmc_spi_arbiter`.

## Test plan
All scenarios use CLK_DIV = 4.
1. **Write:** R0 writes dev = 2, addr = 0x0008, wdata = 0xA5 → `spi_csb_ad9213` low for 196 cycles; 0x0008A5 appears MSB-first on the SCLK rising edges; `ack[0]` at T+197; `err` = 0; `rdata` = 0.
2. **Read:** R1 reads dev = 0, addr = 0x0001; the slave model drives 0x5C → `spi_slen_hmc7044` high; `spi_data_oe` low for bits 7..0; `ack[1]` with `rdata` = 0x5C.
3. **Contention:** R0 and R1 both raise `req` in the same cycle and hold it across 4 frames → without the macro the order is R0,R0,R0,R0 and R1 waits; with `HTG_SPI_RR_EN` the order is R0,R1,R0,R1.
4. **Invalid device:** R0 sends dev = 3 → `ack[0]` and `err` = 1 at T+1; no select, SCLK or OE activity.
5. **Reset mid-frame:** `reset_n` is low during bit 10 → all outputs at reset values in the same cycle and no `ack`; after release with `req` still held, the frame restarts with bit 23 at T+1.
